// File: rtl/reg_initiator.sv
// Single-outstanding register bus initiator: one bus op per accepted request,
// read data captured a fixed number of edges after the RD op and held until consumed.
module reg_initiator #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic [1:0]        reg_op,
  output logic [AWIDTH-1:0] reg_addr,
  output logic [DWIDTH-1:0] reg_wdata,
  input  logic [DWIDTH-1:0] reg_rdata
);
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [1:0] OP_NOP = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: ;
      ISSUE: begin
        op_d = OP_NOP;
        if (op_q == OP_WR) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = reg_rdata;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An accept (IDLE, or a WR in ISSUE) overrides the fall-back to NOP so writes can stream.
    if (accept) begin
      state_d = ISSUE;
      addr_d  = req_addr;
      op_d    = req_write ? OP_WR : OP_RD;
      if (req_write) wdata_d = req_wdata;
    end
  end

  always_comb begin
    req_ready = !rst && ((state_q == IDLE) || (state_q == ISSUE && op_q == OP_WR));
  end

  assign reg_op    = op_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_reg_initiator.sv
// Bench for reg_initiator: directed cases plus a random request/response mix
// against a request-level memory model and two-register responders.
module tb_reg_initiator;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata, rsp_rdata, reg_addr, reg_wdata, reg_rdata;
  logic [1:0] reg_op;

  logic       b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
  logic [7:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_reg_addr, b_reg_wdata, b_reg_rdata;
  logic [1:0] b_reg_op;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  reg_initiator #(.DWIDTH(8), .AWIDTH(8), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .reg_op(reg_op), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata));

  reg_initiator #(.DWIDTH(8), .AWIDTH(8), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .reg_op(b_reg_op), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_rdata(b_reg_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Responders: latency-1 registered data, latency-3 pipeline; random junk when not returning data.
  logic [7:0] mem_a [2];
  logic [7:0] mem_b [2];
  logic [7:0] bp1, bp2;
  logic       bv1, bv2;
  always @(posedge clk) begin
    if (reg_op == 2'b10) mem_a[reg_addr[0]] <= reg_wdata;
    reg_rdata <= (reg_op == 2'b01) ? mem_a[reg_addr[0]] : 8'($urandom);
  end
  always @(posedge clk) begin
    if (b_reg_op == 2'b10) mem_b[b_reg_addr[0]] <= b_reg_wdata;
    bp1 <= (b_reg_op == 2'b01) ? mem_b[b_reg_addr[0]] : 8'($urandom);
    bv1 <= (b_reg_op == 2'b01);
    bp2 <= bp1;
    bv2 <= bv1;
    b_reg_rdata <= bv2 ? bp2 : 8'($urandom);
  end

  // Request-level reference model for the latency-1 instance.
  typedef struct { logic [1:0] op; logic [7:0] a; logic [7:0] d; } bus_t;
  typedef struct { logic [7:0] d; int c; } rd_t;
  bus_t       bus_q[$];
  rd_t        rd_q[$];
  logic [7:0] mem_m [2] = '{default: 8'h00};
  logic [7:0] last_wd = 8'h00, rd_prev = 8'h00, last_rsp = 8'h00;
  logic       acc_prev = 1'b0, rv_prev = 1'b0, rr_prev = 1'b0, mon_en = 1'b0, rnd_rr = 1'b0;
  int         cyc = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (acc_prev && bus_q.size() > 0) begin
        bus_t be;
        be = bus_q.pop_front();
        chk("bus_op", 32'(reg_op), 32'(be.op));
        chk("bus_addr", 32'(reg_addr), 32'(be.a));
        chk("bus_wdata", 32'(reg_wdata), 32'(be.d));
      end else begin
        chk("bus_nop", 32'(reg_op), 32'(2'b00));
      end
      acc_prev = req_valid && req_ready;
      if (acc_prev) begin
        if (req_write) begin
          mem_m[req_addr[0]] = req_wdata;
          last_wd = req_wdata;
          bus_q.push_back('{2'b10, req_addr, req_wdata});
        end else begin
          bus_q.push_back('{2'b01, req_addr, last_wd});
          rd_q.push_back('{mem_m[req_addr[0]], cyc});
        end
      end
      if (rsp_valid) begin
        if (rd_q.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid), 32'(1'b0));
        end else begin
          if (!rv_prev) chk("rsp_latency", 32'(cyc), 32'(rd_q[0].c + 3));
          else if (!rr_prev) chk("rsp_hold", 32'(rsp_rdata), 32'(rd_prev));
          chk("ready_in_resp", 32'(req_ready), 32'(1'b0));
          if (rsp_ready) begin
            chk("rsp_data", 32'(rsp_rdata), 32'(rd_q[0].d));
            last_rsp = rsp_rdata;
            void'(rd_q.pop_front());
          end
        end
      end
      rv_prev = rsp_valid;
      rr_prev = rsp_ready;
      rd_prev = rsp_rdata;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rr) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_accept", 32'(req_ready), 32'(1'b1));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && bus_q.size() == 0 && !rsp_valid) break;
    end
    chk("idle_rd", 32'(rd_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_reg_op", 32'(reg_op), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Latency-3 instance: write then read addr 1, response exactly 5 negedges after the accept edge.
    b_req_valid = 1; b_req_write = 1; b_req_addr = 8'h01; b_req_wdata = 8'hC3;
    @(negedge clk); chk("b_rdy_wr", 32'(b_req_ready), 1);
    @(posedge clk); #1 b_req_write = 0; b_req_wdata = 8'h77;
    @(negedge clk);
    chk("b_rdy_rd", 32'(b_req_ready), 1);
    chk("b_wr_op", 32'(b_reg_op), 32'(2'b10));
    @(posedge clk); #1 b_req_valid = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b_rsp_valid) break;
    end
    chk("b_latency", 32'(n), 5);
    chk("b_data", 32'(b_rsp_rdata), 32'(8'hC3));
    @(posedge clk); #1;

    mon_en = 1'b1;
    rsp_ready = 1'b1;
    do_req(1'b1, 8'h00, 8'h5A);
    do_req(1'b0, 8'h00, 8'hEE);
    wait_idle();
    chk("t1_read", 32'(last_rsp), 32'(8'h5A));

    do_req(1'b1, 8'h00, 8'h01);
    do_req(1'b1, 8'h01, 8'h02);
    do_req(1'b1, 8'h00, 8'h03);
    do_req(1'b1, 8'h01, 8'h04);
    wait_idle();
    do_req(1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("t2_reg0", 32'(last_rsp), 32'(8'h03));
    do_req(1'b0, 8'h01, 8'h00);
    wait_idle();
    chk("t2_reg1", 32'(last_rsp), 32'(8'h04));

    // Response back-pressure.
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h01, 8'h99);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", 32'(rsp_rdata), 32'(8'h04));
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_op", 32'(reg_op), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    chk("bp_done", 32'(last_rsp), 32'(8'h04));

    // Reset while waiting for read data.
    do_req(1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rw_op", 32'(reg_op), 0);
    chk("rw_rsp_valid", 32'(rsp_valid), 0);
    chk("rw_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    bus_q.delete(); rd_q.delete();
    acc_prev = 0; rv_prev = 0; rr_prev = 0; last_wd = 8'h00;
    mon_en = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    do_req(1'b0, 8'h00, 8'h42);
    wait_idle();
    chk("rw_after", 32'(last_rsp), 32'(8'h03));

    // Random mix with random gaps and response back-pressure.
    rnd_rr = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 8'($urandom));
    end
    rnd_rr = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("end_bus_q", 32'(bus_q.size()), 0);
    chk("end_rd_q", 32'(rd_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end
endmodule
